// File: rtl/superscalar_pkg.sv
`default_nettype none
// ============================================================================
// Package     : superscalar_pkg
// Description : Shared definitions for the superscalar front end: instruction
//               field geometry, the HALT opcode, the instruction word type and
//               the fetch FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package superscalar_pkg;

  // Each instruction is four equal fields: type | dest | src0 | src1.
  localparam int INS_PART_WID = 4;
  localparam int c_ins_wid    = 4 * INS_PART_WID;

  localparam logic [INS_PART_WID-1:0] HALT_OPCODE = 4'hF;

  // Field slice positions for the default field width.
  localparam int c_type_msb = 15;
  localparam int c_type_lsb = 12;
  localparam int c_dest_msb = 11;
  localparam int c_dest_lsb = 8;
  localparam int c_src0_msb = 7;
  localparam int c_src0_lsb = 4;
  localparam int c_src1_msb = 3;
  localparam int c_src1_lsb = 0;

  typedef logic [c_ins_wid-1:0] ins_word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_prog_mem.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prog_mem
// Description : Program memory for the fetch unit. DEPTH x WID storage with
//               one synchronous write port and two combinational read ports
//               (one per fetch slot). Contents are never reset.
// Revision    : 1.0 - initial release
// Ports       : clk              - clock
//               we/waddr/wdata   - synchronous write port
//               raddr_a/rdata_a  - read port for the first fill slot
//               raddr_b/rdata_b  - read port for the second fill slot
// ============================================================================
module fetch_prog_mem #(
  parameter int DEPTH = 32,
  parameter int WID   = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WID-1:0]           wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr_a,
  output logic [WID-1:0]           rdata_a,
  input  logic [$clog2(DEPTH)-1:0] raddr_b,
  output logic [WID-1:0]           rdata_b
);
  import superscalar_pkg::*;

  logic [WID-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata_a = r_mem[raddr_a];
  assign rdata_b = r_mem[raddr_b];

endmodule
`default_nettype wire

// File: rtl/dual_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : dual_fetch_unit
// Description : Dual-issue instruction fetch stage. Holds a loadable program
//               memory and a PC and presents up to two in-order instructions
//               per cycle on two valid/ready lanes. Fetch stops on a HALT
//               opcode or after the last memory word.
// Revision    : 1.0 - initial release
// Options     : FETCH_PERF_CNT_EN - adds issued_cnt / stall_cnt counters
// Ports       : clk, rst                 - clock, async active-high reset
//               prog_we/addr/wdata       - program load (IDLE/HALT only)
//               start                    - begin fetch from address 0
//               instruction_1/val_1/rdy_1 - older lane
//               instruction_2/val_2/rdy_2 - younger lane
//               busy                     - FETCH or DRAIN
//               done                     - HALT
//               issued_cnt, stall_cnt    - perf counters (optional)
// ============================================================================
module dual_fetch_unit #(
  parameter int                       INS_PART_WID = superscalar_pkg::INS_PART_WID,
  parameter int                       PROG_DEPTH   = 32,
  parameter logic [INS_PART_WID-1:0]  HALT_OPCODE  = superscalar_pkg::HALT_OPCODE
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          prog_we,
  input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
  input  logic [4*INS_PART_WID-1:0]     prog_wdata,
  input  logic                          start,
  output logic [4*INS_PART_WID-1:0]     instruction_1,
  output logic                          instruction_val_1,
  input  logic                          instruction_rdy_1,
  output logic [4*INS_PART_WID-1:0]     instruction_2,
  output logic                          instruction_val_2,
  input  logic                          instruction_rdy_2,
  output logic                          busy,
  output logic                          done
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]                   issued_cnt,
  output logic [15:0]                   stall_cnt
`endif
);
  import superscalar_pkg::*;

  localparam int c_aw = $clog2(PROG_DEPTH);
  localparam int c_iw = 4 * INS_PART_WID;
  localparam logic [c_aw-1:0] c_last_addr = c_aw'(PROG_DEPTH - 1);

  fetch_state_t    r_state, w_state_nxt;
  logic [c_aw-1:0] r_pc, w_pc_nxt, w_pc_plus1;
  logic [c_iw-1:0] r_lane1, r_lane2, w_lane1_nxt, w_lane2_nxt;
  logic            r_val1, r_val2, w_val1_nxt, w_val2_nxt;
  logic [c_iw-1:0] w_word_a, w_word_b;
  logic            w_halt_a, w_halt_b;
  logic            w_cons1, w_cons2;
  logic            w_start_ok;
  logic            w_mem_we;

  // Program loads are only accepted while the core is not fetching.
  assign w_mem_we   = prog_we && (r_state == ST_IDLE || r_state == ST_HALT);
  assign w_start_ok = start   && (r_state == ST_IDLE || r_state == ST_HALT);
  assign w_pc_plus1 = r_pc + c_aw'(1);

  fetch_prog_mem #(
    .DEPTH (PROG_DEPTH),
    .WID   (c_iw)
  ) u_prog_mem (
    .clk     (clk),
    .we      (w_mem_we),
    .waddr   (prog_addr),
    .wdata   (prog_wdata),
    .raddr_a (r_pc),
    .rdata_a (w_word_a),
    .raddr_b (w_pc_plus1),
    .rdata_b (w_word_b)
  );

  assign w_halt_a = (w_word_a[c_iw-1 -: INS_PART_WID] == HALT_OPCODE);
  assign w_halt_b = (w_word_b[c_iw-1 -: INS_PART_WID] == HALT_OPCODE);

  // Lane 2 can only leave together with lane 1 so order is never broken.
  assign w_cons1 = r_val1 && instruction_rdy_1;
  assign w_cons2 = r_val2 && instruction_rdy_2 && w_cons1;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_lane1_nxt = r_lane1;
    w_lane2_nxt = r_lane2;
    w_val1_nxt  = r_val1;
    w_val2_nxt  = r_val2;

    // Retire consumed lanes; a surviving lane 2 becomes the older entry.
    if (w_cons1) begin
      if (r_val2 && !w_cons2) begin
        w_lane1_nxt = r_lane2;
        w_val1_nxt  = 1'b1;
        w_val2_nxt  = 1'b0;
      end else begin
        w_val1_nxt = 1'b0;
        w_val2_nxt = 1'b0;
      end
    end

    case (r_state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          w_state_nxt = ST_FETCH;
          w_pc_nxt    = '0;
        end
      end

      ST_FETCH: begin
        if (!w_val1_nxt) begin
          // Both slots free: mem[pc] -> lane 1, mem[pc+1] -> lane 2.
          if (w_halt_a) begin
            w_state_nxt = ST_DRAIN;
          end else begin
            w_lane1_nxt = w_word_a;
            w_val1_nxt  = 1'b1;
            if (r_pc == c_last_addr) begin
              // pc+1 would wrap; the last word ends the program.
              w_pc_nxt    = w_pc_plus1;
              w_state_nxt = ST_DRAIN;
            end else if (w_halt_b) begin
              w_pc_nxt    = w_pc_plus1;
              w_state_nxt = ST_DRAIN;
            end else begin
              w_lane2_nxt = w_word_b;
              w_val2_nxt  = 1'b1;
              w_pc_nxt    = r_pc + c_aw'(2);
              if (w_pc_plus1 == c_last_addr) begin
                w_state_nxt = ST_DRAIN;
              end
            end
          end
        end else if (!w_val2_nxt) begin
          // Only lane 2 free: mem[pc] -> lane 2.
          if (w_halt_a) begin
            w_state_nxt = ST_DRAIN;
          end else begin
            w_lane2_nxt = w_word_a;
            w_val2_nxt  = 1'b1;
            w_pc_nxt    = w_pc_plus1;
            if (r_pc == c_last_addr) begin
              w_state_nxt = ST_DRAIN;
            end
          end
        end
      end

      ST_DRAIN: begin
        if (!w_val1_nxt) begin
          w_state_nxt = ST_HALT;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_lane1 <= '0;
      r_lane2 <= '0;
      r_val1  <= 1'b0;
      r_val2  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_lane1 <= w_lane1_nxt;
      r_lane2 <= w_lane2_nxt;
      r_val1  <= w_val1_nxt;
      r_val2  <= w_val2_nxt;
    end
  end

  assign instruction_1     = r_lane1;
  assign instruction_2     = r_lane2;
  assign instruction_val_1 = r_val1;
  assign instruction_val_2 = r_val2;
  assign busy              = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
  assign done              = (r_state == ST_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_issued_cnt, r_stall_cnt;
  logic [16:0] w_issued_sum;

  assign w_issued_sum = {1'b0, r_issued_cnt} + 17'(w_cons1) + 17'(w_cons2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issued_cnt <= '0;
      r_stall_cnt  <= '0;
    end else if (w_start_ok) begin
      r_issued_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      r_issued_cnt <= w_issued_sum[16] ? 16'hFFFF : w_issued_sum[15:0];
      if (r_val1 && !instruction_rdy_1 && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign issued_cnt = r_issued_cnt;
  assign stall_cnt  = r_stall_cnt;
`else
  logic w_unused_start_ok;
  assign w_unused_start_ok = w_start_ok;
`endif

endmodule
`default_nettype wire
